// File: rtl/vram_pixel_writer.sv
// vram_pixel_writer: plots single pixels into ZX Spectrum screen RAM.
// Each plot is a read-modify-write of the bitmap byte and, optionally, of
// the attribute byte (ink field only). The screen layout matches the display
// fetch path, so plotted pixels show up unchanged.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   req_valid/req_ready plot command handshake (ready only while idle)
//   req_x, req_y        pixel column 0..255, line 0..Y_LINES-1
//   req_op              00 clear, 01 set, 10 toggle, 11 attribute only
//   req_ink, req_attr_we ink colour and attribute-update enable
//   done, err           one-cycle pulses: command finished / rejected
//   cls_start, cls_attr screen clear trigger and attribute fill value
//   ad_video, din_video, we_video, dout_video  single-port sync RAM
//
// Build option: define CLS_EN to enable the whole-screen clear. Without it
// cls_start and cls_attr are ignored.

module vram_pixel_writer #(
    parameter int ATTR_BASE = 6144,
    parameter int Y_LINES   = 192
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_x,
    input  logic [7:0]  req_y,
    input  logic [1:0]  req_op,
    input  logic [2:0]  req_ink,
    input  logic        req_attr_we,
    output logic        done,
    output logic        err,
    input  logic        cls_start,
    input  logic [7:0]  cls_attr,
    output logic [12:0] ad_video,
    output logic [7:0]  din_video,
    output logic        we_video,
    input  logic [7:0]  dout_video
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_ERR       = 4'd1;
    localparam logic [3:0] S_RD_PIX    = 4'd2;
    localparam logic [3:0] S_WAIT_PIX  = 4'd3;
    localparam logic [3:0] S_WR_PIX    = 4'd4;
    localparam logic [3:0] S_RD_ATTR   = 4'd5;
    localparam logic [3:0] S_WAIT_ATTR = 4'd6;
    localparam logic [3:0] S_WR_ATTR   = 4'd7;
    localparam logic [3:0] S_DONE      = 4'd8;
`ifdef CLS_EN
    localparam logic [3:0] S_CLS_FILL  = 4'd9;
    localparam int         CLS_LAST    = ATTR_BASE + 767;
`endif

    logic [3:0]  state;
    logic [3:0]  state_next;
    logic [7:0]  x_q;
    logic [7:0]  y_q;
    logic [1:0]  op_q;
    logic [2:0]  ink_q;
    logic        attr_we_q;
    logic [7:0]  data_q;
    logic        take_req;
    logic        y_bad;
    logic [12:0] pix_addr;
    logic [12:0] attr_addr;
    logic [7:0]  mask;
    logic [7:0]  pix_new;

`ifdef CLS_EN
    logic [12:0] cls_cnt;
    logic [7:0]  cls_attr_q;
    logic        take_cls;

    assign take_cls  = (state == S_IDLE) && !reset && cls_start;
    // A clear request wins over a plot request in the same cycle.
    assign req_ready = (state == S_IDLE) && !reset && !cls_start;
`else
    logic unused_cls;

    assign unused_cls = ^{cls_start, cls_attr};
    assign req_ready  = (state == S_IDLE) && !reset;
`endif

    assign take_req = req_valid && req_ready;
    assign y_bad    = {24'd0, req_y} >= Y_LINES;

    // Spectrum bitmap interleave: third, pixel row in cell, cell row, column.
    assign pix_addr  = {y_q[7:6], y_q[2:0], y_q[5:3], x_q[7:3]};
    assign attr_addr = 13'(ATTR_BASE) + {3'b000, y_q[7:3], x_q[7:3]};
    // x=0 is the leftmost pixel, held in bit 7.
    assign mask      = 8'h80 >> x_q[2:0];

    always_comb begin
        pix_new = data_q;
        case (op_q)
            2'b00:   pix_new = data_q & ~mask;
            2'b01:   pix_new = data_q | mask;
            2'b10:   pix_new = data_q ^ mask;
            default: pix_new = data_q;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
`ifdef CLS_EN
                if (take_cls) begin
                    state_next = S_CLS_FILL;
                end else
`endif
                if (take_req) begin
                    if (y_bad) begin
                        state_next = S_ERR;
                    end else if (req_op == 2'b11) begin
                        state_next = S_RD_ATTR;
                    end else begin
                        state_next = S_RD_PIX;
                    end
                end
            end
            S_ERR:       state_next = S_IDLE;
            S_RD_PIX:    state_next = S_WAIT_PIX;
            S_WAIT_PIX:  state_next = S_WR_PIX;
            S_WR_PIX: begin
                if (attr_we_q || op_q == 2'b11) begin
                    state_next = S_RD_ATTR;
                end else begin
                    state_next = S_DONE;
                end
            end
            S_RD_ATTR:   state_next = S_WAIT_ATTR;
            S_WAIT_ATTR: state_next = S_WR_ATTR;
            S_WR_ATTR:   state_next = S_DONE;
            S_DONE:      state_next = S_IDLE;
`ifdef CLS_EN
            S_CLS_FILL: begin
                if (cls_cnt == 13'(CLS_LAST)) begin
                    state_next = S_DONE;
                end
            end
`endif
            default:     state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            x_q       <= 8'd0;
            y_q       <= 8'd0;
            op_q      <= 2'd0;
            ink_q     <= 3'd0;
            attr_we_q <= 1'b0;
            data_q    <= 8'd0;
        end else begin
            state <= state_next;
            if (take_req) begin
                x_q       <= req_x;
                y_q       <= req_y;
                op_q      <= req_op;
                ink_q     <= req_ink;
                attr_we_q <= req_attr_we;
            end
            if (state == S_WAIT_PIX || state == S_WAIT_ATTR) begin
                data_q <= dout_video;
            end
        end
    end

`ifdef CLS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cls_cnt    <= 13'd0;
            cls_attr_q <= 8'd0;
        end else if (take_cls) begin
            cls_cnt    <= 13'd0;
            cls_attr_q <= cls_attr;
        end else if (state == S_CLS_FILL) begin
            cls_cnt <= cls_cnt + 13'd1;
        end
    end
`endif

    always_comb begin
        ad_video  = 13'd0;
        din_video = 8'd0;
        we_video  = 1'b0;
        case (state)
            S_RD_PIX: ad_video = pix_addr;
            S_WR_PIX: begin
                ad_video  = pix_addr;
                din_video = pix_new;
                we_video  = 1'b1;
            end
            S_RD_ATTR: ad_video = attr_addr;
            S_WR_ATTR: begin
                // Only the ink field changes; paper, bright, flash stay.
                ad_video  = attr_addr;
                din_video = {data_q[7:3], ink_q};
                we_video  = 1'b1;
            end
`ifdef CLS_EN
            S_CLS_FILL: begin
                ad_video  = cls_cnt;
                din_video = (cls_cnt < 13'(ATTR_BASE)) ? 8'h00 : cls_attr_q;
                we_video  = 1'b1;
            end
`endif
            default: begin
                ad_video  = 13'd0;
                din_video = 8'd0;
                we_video  = 1'b0;
            end
        endcase
    end

    assign done = (state == S_DONE);
    assign err  = (state == S_ERR);

endmodule
